// File: rtl/riscv_multicycle_ctrl_pkg.sv
// Shared types and constants for the multi-cycle RISC-V main control FSM.
// Holds the state encoding, opcode/ALUOp/mux-select constants and the retire decode.
package riscv_ctrl_pkg;

   typedef enum logic [3:0] {
      ST_FETCH  = 4'd0,
      ST_DECODE = 4'd1,
      ST_MEMADR = 4'd2,
      ST_MEMRD  = 4'd3,
      ST_MEMWB  = 4'd4,
      ST_MEMWR  = 4'd5,
      ST_EXEC_R = 4'd6,
      ST_EXEC_I = 4'd7,
      ST_ALUWB  = 4'd8,
      ST_BRANCH = 4'd9,
      ST_TRAP   = 4'd10
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'd0;
   localparam logic [1:0] SRCA_REG   = 2'd1;
   localparam logic [1:0] SRCA_OLDPC = 2'd2;

   localparam logic [1:0] SRCB_REG  = 2'd0;
   localparam logic [1:0] SRCB_FOUR = 2'd1;
   localparam logic [1:0] SRCB_IMM  = 2'd2;

   // A store only retires once the memory accepts the write.
   function automatic logic is_retiring(input state_t st, input logic rdy);
      logic ret;
      case (st)
         ST_MEMWB, ST_ALUWB, ST_BRANCH: ret = 1'b1;
         ST_MEMWR:                      ret = rdy;
         default:                       ret = 1'b0;
      endcase
      return ret;
   endfunction

endpackage

// File: rtl/riscv_multicycle_ctrl_if.sv
// Control bundle between the main FSM (master) and the multi-cycle datapath (slave).
interface riscv_multicycle_ctrl_if;

   logic [6:0] opcode;
   logic       zero;
   logic       mem_ready;
   logic       mem_req;
   logic       MemWrite;
   logic       IorD;
   logic       IRWrite;
   logic       PCWrite;
   logic       PCSource;
   logic [1:0] ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [1:0] ALUOp;
   logic       RegWrite;
   logic       MemtoReg;
   logic       trap;

   modport master (
      input  opcode, zero, mem_ready,
      output mem_req, MemWrite, IorD, IRWrite, PCWrite, PCSource,
             ALUSrcA, ALUSrcB, ALUOp, RegWrite, MemtoReg, trap
   );

   modport slave (
      output opcode, zero, mem_ready,
      input  mem_req, MemWrite, IorD, IRWrite, PCWrite, PCSource,
             ALUSrcA, ALUSrcB, ALUOp, RegWrite, MemtoReg, trap
   );

endinterface

// File: rtl/riscv_multicycle_ctrl_counters.sv
// Free-running cycle counter and retired-instruction counter, both wrapping.
module ctrl_counters #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             count_en,
   input  logic             retire,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] instret_cnt
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [CNT_W-1:0] cycle_r;
   logic [CNT_W-1:0] instret_r;

   // Counter registers; natural overflow provides the wrap to zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cycle_r   <= '0;
         instret_r <= '0;
      end else begin
         if (count_en) begin
            cycle_r <= cycle_r + CNT_ONE;
         end
         if (count_en && retire) begin
            instret_r <= instret_r + CNT_ONE;
         end
      end
   end

   assign cycle_cnt   = cycle_r;
   assign instret_cnt = instret_r;

endmodule

// File: rtl/riscv_multicycle_ctrl.sv
// Main control FSM of the multi-cycle RISC-V core: sequences ALU, unified memory
// port and register file, and keeps cycle / instret counters.
module riscv_multicycle_ctrl
   import riscv_ctrl_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   riscv_multicycle_ctrl_if.master  bus,
   output logic [CNT_W-1:0]         cycle_cnt,
   output logic [CNT_W-1:0]         instret_cnt
);

   state_t     state_r;
   state_t     next_s;
   logic       is_store_r;
   logic       retire_s;

   logic       mem_req_s, memwrite_s, iord_s, irwrite_s, pcwrite_s, pcsource_s;
   logic [1:0] srca_s, srcb_s, aluop_s;
   logic       regwrite_s, memtoreg_s, trap_s;

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= ST_FETCH;
      end else begin
         state_r <= next_s;
      end
   end

   // Load/store kind is captured in DECODE so MEMADR never looks at the opcode.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         is_store_r <= 1'b0;
      end else if (state_r == ST_DECODE) begin
         is_store_r <= (bus.opcode == OP_STORE);
      end else begin
         is_store_r <= is_store_r;
      end
   end

   // Next-state and output decode.
   always_comb begin
      next_s     = state_r;
      mem_req_s  = 1'b0;
      memwrite_s = 1'b0;
      iord_s     = 1'b0;
      irwrite_s  = 1'b0;
      pcwrite_s  = 1'b0;
      pcsource_s = 1'b0;
      srca_s     = SRCA_PC;
      srcb_s     = SRCB_REG;
      aluop_s    = ALUOP_ADD;
      regwrite_s = 1'b0;
      memtoreg_s = 1'b0;
      trap_s     = 1'b0;
      case (state_r)
         ST_FETCH: begin
            mem_req_s = 1'b1;
            srcb_s    = SRCB_FOUR;
            if (bus.mem_ready) begin
               irwrite_s = 1'b1;
               pcwrite_s = 1'b1;
               next_s    = ST_DECODE;
            end else begin
               next_s    = ST_FETCH;
            end
         end
         ST_DECODE: begin
            srca_s = SRCA_OLDPC;
            srcb_s = SRCB_IMM;
            case (bus.opcode)
               OP_LOAD, OP_STORE: next_s = ST_MEMADR;
               OP_RTYPE:          next_s = ST_EXEC_R;
               OP_ITYPE:          next_s = ST_EXEC_I;
               OP_BRANCH:         next_s = ST_BRANCH;
               default:           next_s = ST_TRAP;
            endcase
         end
         ST_MEMADR: begin
            srca_s = SRCA_REG;
            srcb_s = SRCB_IMM;
            if (is_store_r) begin
               next_s = ST_MEMWR;
            end else begin
               next_s = ST_MEMRD;
            end
         end
         ST_MEMRD: begin
            mem_req_s = 1'b1;
            iord_s    = 1'b1;
            next_s    = bus.mem_ready ? ST_MEMWB : ST_MEMRD;
         end
         ST_MEMWB: begin
            regwrite_s = 1'b1;
            memtoreg_s = 1'b1;
            next_s     = ST_FETCH;
         end
         ST_MEMWR: begin
            mem_req_s  = 1'b1;
            memwrite_s = 1'b1;
            iord_s     = 1'b1;
            next_s     = bus.mem_ready ? ST_FETCH : ST_MEMWR;
         end
         ST_EXEC_R: begin
            srca_s  = SRCA_REG;
            srcb_s  = SRCB_REG;
            aluop_s = ALUOP_FUNCT;
            next_s  = ST_ALUWB;
         end
         ST_EXEC_I: begin
            srca_s  = SRCA_REG;
            srcb_s  = SRCB_IMM;
            aluop_s = ALUOP_FUNCT;
            next_s  = ST_ALUWB;
         end
         ST_ALUWB: begin
            regwrite_s = 1'b1;
            next_s     = ST_FETCH;
         end
         ST_BRANCH: begin
            srca_s     = SRCA_REG;
            srcb_s     = SRCB_REG;
            aluop_s    = ALUOP_SUB;
            pcsource_s = 1'b1;
            pcwrite_s  = bus.zero;
            next_s     = ST_FETCH;
         end
         ST_TRAP: begin
            trap_s = 1'b1;
            next_s = ST_TRAP;
         end
         default: begin
            next_s = ST_FETCH;
         end
      endcase
   end

   // Reset overrides every output combinationally so nothing leaks out mid-abort.
   assign bus.mem_req  = mem_req_s  & ~reset;
   assign bus.MemWrite = memwrite_s & ~reset;
   assign bus.IorD     = iord_s     & ~reset;
   assign bus.IRWrite  = irwrite_s  & ~reset;
   assign bus.PCWrite  = pcwrite_s  & ~reset;
   assign bus.PCSource = pcsource_s & ~reset;
   assign bus.ALUSrcA  = reset ? 2'b00 : srca_s;
   assign bus.ALUSrcB  = reset ? 2'b00 : srcb_s;
   assign bus.ALUOp    = reset ? 2'b00 : aluop_s;
   assign bus.RegWrite = regwrite_s & ~reset;
   assign bus.MemtoReg = memtoreg_s & ~reset;
   assign bus.trap     = trap_s     & ~reset;

   assign retire_s = is_retiring(state_r, bus.mem_ready);

   ctrl_counters #(
      .CNT_W (CNT_W)
   ) u_counters (
      .clk         (clk),
      .reset       (reset),
      .count_en    (1'b1),
      .retire      (retire_s),
      .cycle_cnt   (cycle_cnt),
      .instret_cnt (instret_cnt)
   );

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Directed scoreboard bench for riscv_multicycle_ctrl: per-cycle expected control
// vectors and counter values are queued at drive time and compared at sample time.
module tb_riscv_multicycle_ctrl;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   riscv_multicycle_ctrl_if bus ();
   riscv_multicycle_ctrl_if bus2 ();

   logic [31:0] cycle_cnt, instret_cnt;
   logic [3:0]  cycle_cnt2, instret_cnt2;

   riscv_multicycle_ctrl #(.CNT_W(32)) dut (
      .clk (clk), .reset (reset), .bus (bus),
      .cycle_cnt (cycle_cnt), .instret_cnt (instret_cnt)
   );

   riscv_multicycle_ctrl #(.CNT_W(4)) dut4 (
      .clk (clk), .reset (reset), .bus (bus2),
      .cycle_cnt (cycle_cnt2), .instret_cnt (instret_cnt2)
   );

   // {mem_req, MemWrite, IorD, IRWrite, PCWrite, PCSource, ALUSrcA, ALUSrcB, ALUOp, RegWrite, MemtoReg, trap}
   logic [14:0] ctl_obs;
   assign ctl_obs = {bus.mem_req, bus.MemWrite, bus.IorD, bus.IRWrite, bus.PCWrite, bus.PCSource,
                     bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.RegWrite, bus.MemtoReg, bus.trap};

   localparam logic [14:0] V_NONE    = 15'b0_0_0_0_0_0_00_00_00_0_0_0;
   localparam logic [14:0] V_FETCH   = 15'b1_0_0_1_1_0_00_01_00_0_0_0;
   localparam logic [14:0] V_FWAIT   = 15'b1_0_0_0_0_0_00_01_00_0_0_0;
   localparam logic [14:0] V_DECODE  = 15'b0_0_0_0_0_0_10_10_00_0_0_0;
   localparam logic [14:0] V_MEMADR  = 15'b0_0_0_0_0_0_01_10_00_0_0_0;
   localparam logic [14:0] V_MEMRD   = 15'b1_0_1_0_0_0_00_00_00_0_0_0;
   localparam logic [14:0] V_MEMWB   = 15'b0_0_0_0_0_0_00_00_00_1_1_0;
   localparam logic [14:0] V_MEMWR   = 15'b1_1_1_0_0_0_00_00_00_0_0_0;
   localparam logic [14:0] V_EXEC_R  = 15'b0_0_0_0_0_0_01_00_10_0_0_0;
   localparam logic [14:0] V_EXEC_I  = 15'b0_0_0_0_0_0_01_10_10_0_0_0;
   localparam logic [14:0] V_ALUWB   = 15'b0_0_0_0_0_0_00_00_00_1_0_0;
   localparam logic [14:0] V_BR_TAKE = 15'b0_0_0_0_1_1_01_00_01_0_0_0;
   localparam logic [14:0] V_BR_NOT  = 15'b0_0_0_0_0_1_01_00_01_0_0_0;
   localparam logic [14:0] V_TRAP    = 15'b0_0_0_0_0_0_00_00_00_0_0_1;

   localparam logic [6:0] O_LOAD   = 7'b0000011;
   localparam logic [6:0] O_STORE  = 7'b0100011;
   localparam logic [6:0] O_RTYPE  = 7'b0110011;
   localparam logic [6:0] O_ITYPE  = 7'b0010011;
   localparam logic [6:0] O_BRANCH = 7'b1100011;
   localparam logic [6:0] O_JUNK   = 7'b1111111;

   typedef struct {
      string       tag;
      logic [14:0] ctl;
      logic [31:0] cyc;
      logic [31:0] ret;
   } exp_t;

   exp_t        sb[$];
   int          errors = 0;
   int          checks = 0;
   logic [31:0] exp_cyc = 32'd0;
   logic [31:0] exp_ret = 32'd0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_out();
      exp_t e;
      e = sb.pop_front();
      chk({e.tag, "_ctl"}, {17'd0, ctl_obs}, {17'd0, e.ctl});
      chk({e.tag, "_cyc"}, cycle_cnt, e.cyc);
      chk({e.tag, "_ret"}, instret_cnt, e.ret);
   endtask

   // One clock cycle: drive inputs, queue the expectation, sample before the next edge.
   task automatic step(input string tag, input logic [6:0] opc, input logic z, input logic rdy,
                       input logic [14:0] ectl, input bit retires);
      exp_t e;
      @(negedge clk);
      bus.opcode = opc;
      bus.zero = z;
      bus.mem_ready = rdy;
      e.tag = tag; e.ctl = ectl; e.cyc = exp_cyc; e.ret = exp_ret;
      sb.push_back(e);
      #1;
      check_out();
      if (retires) exp_ret = exp_ret + 32'd1;
      exp_cyc = exp_cyc + 32'd1;
   endtask

   // Assert reset mid-cycle, check the forced-zero outputs, release just after an edge.
   task automatic reset_now(input string tag);
      reset = 1'b1;
      #1;
      chk({tag, "_ctl"}, {17'd0, ctl_obs}, 32'd0);
      chk({tag, "_cyc"}, cycle_cnt, 32'd0);
      chk({tag, "_ret"}, instret_cnt, 32'd0);
      @(negedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
      exp_cyc = 32'd0;
      exp_ret = 32'd0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.opcode = 7'd0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
      bus2.opcode = O_RTYPE; bus2.zero = 1'b0; bus2.mem_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_cnt4", {28'd0, cycle_cnt2}, 32'd0);
      reset_now("rst_init");

      // Sixteen ALU instructions; the 4-bit instance wraps both counters at the same time.
      for (int i = 0; i < 16; i++) begin
         step("alu_fetch", O_JUNK, 1'b1, 1'b1, V_FETCH, 1'b0);
         if (i == 15) begin
            chk("wrap_cyc_pre", {28'd0, cycle_cnt2}, 32'd12);
            chk("wrap_ret_pre", {28'd0, instret_cnt2}, 32'd15);
         end
         if (i < 8) begin
            step("r_decode", O_RTYPE, 1'b1, 1'b0, V_DECODE, 1'b0);
            step("r_exec", O_JUNK, 1'b1, 1'b0, V_EXEC_R, 1'b0);
         end else begin
            step("i_decode", O_ITYPE, 1'b1, 1'b0, V_DECODE, 1'b0);
            step("i_exec", O_JUNK, 1'b1, 1'b0, V_EXEC_I, 1'b0);
         end
         step("aluwb", O_JUNK, 1'b1, 1'b0, V_ALUWB, 1'b1);
         if (i == 0) begin
            chk("r_first_ret", instret_cnt, 32'd0);
         end
      end
      @(negedge clk);
      #1;
      chk("wrap_cyc", {28'd0, cycle_cnt2}, 32'd0);
      chk("wrap_ret", {28'd0, instret_cnt2}, 32'd0);
      chk("alu16_ret", instret_cnt, 32'd16);
      chk("alu16_cyc", cycle_cnt, 32'd64);
      @(negedge clk);
      reset_now("rst_after_wrap");

      // Load with three wait cycles in MEMRD: 8 cycles total.
      step("ld_fetch", O_JUNK, 1'b0, 1'b1, V_FETCH, 1'b0);
      step("ld_decode", O_LOAD, 1'b0, 1'b0, V_DECODE, 1'b0);
      step("ld_memadr", O_STORE, 1'b0, 1'b0, V_MEMADR, 1'b0);
      for (int w = 0; w < 3; w++) step("ld_wait", O_STORE, 1'b1, 1'b0, V_MEMRD, 1'b0);
      step("ld_memrd", O_JUNK, 1'b0, 1'b1, V_MEMRD, 1'b0);
      step("ld_memwb", O_JUNK, 1'b0, 1'b0, V_MEMWB, 1'b1);

      // Store with one FETCH wait and one MEMWR wait.
      step("st_fwait", O_JUNK, 1'b0, 1'b0, V_FWAIT, 1'b0);
      step("st_fetch", O_JUNK, 1'b0, 1'b1, V_FETCH, 1'b0);
      step("st_decode", O_STORE, 1'b0, 1'b0, V_DECODE, 1'b0);
      step("st_memadr", O_LOAD, 1'b0, 1'b0, V_MEMADR, 1'b0);
      step("st_wwait", O_LOAD, 1'b0, 1'b0, V_MEMWR, 1'b0);
      step("st_memwr", O_JUNK, 1'b0, 1'b1, V_MEMWR, 1'b1);

      // Branches, taken and not taken.
      step("bt_fetch", O_JUNK, 1'b0, 1'b1, V_FETCH, 1'b0);
      step("bt_decode", O_BRANCH, 1'b0, 1'b0, V_DECODE, 1'b0);
      step("bt_branch", O_JUNK, 1'b1, 1'b0, V_BR_TAKE, 1'b1);
      step("bn_fetch", O_JUNK, 1'b1, 1'b1, V_FETCH, 1'b0);
      step("bn_decode", O_BRANCH, 1'b1, 1'b0, V_DECODE, 1'b0);
      step("bn_branch", O_JUNK, 1'b0, 1'b1, V_BR_NOT, 1'b1);
      step("post_br_fetch", O_JUNK, 1'b0, 1'b1, V_FETCH, 1'b0);
      step("post_br_decode", O_RTYPE, 1'b0, 1'b0, V_DECODE, 1'b0);
      step("post_br_exec", O_JUNK, 1'b0, 1'b0, V_EXEC_R, 1'b0);
      step("post_br_wb", O_JUNK, 1'b0, 1'b0, V_ALUWB, 1'b1);

      // Reset pulsed while a store is stalled in MEMWR.
      step("rw_fetch", O_JUNK, 1'b0, 1'b1, V_FETCH, 1'b0);
      step("rw_decode", O_STORE, 1'b0, 1'b0, V_DECODE, 1'b0);
      step("rw_memadr", O_JUNK, 1'b0, 1'b0, V_MEMADR, 1'b0);
      step("rw_wait", O_JUNK, 1'b0, 1'b0, V_MEMWR, 1'b0);
      reset_now("rst_memwr");
      step("rw_restart", O_JUNK, 1'b0, 1'b0, V_FWAIT, 1'b0);
      step("rw_fetch2", O_JUNK, 1'b0, 1'b1, V_FETCH, 1'b0);

      // Illegal opcode: sticky trap for 20 cycles, instret frozen.
      step("tr_decode", O_JUNK, 1'b0, 1'b1, V_DECODE, 1'b0);
      for (int t = 0; t < 20; t++) begin
         step("trap", 7'($urandom_range(0, 127)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), V_TRAP, 1'b0);
      end
      chk("trap_ret", instret_cnt, 32'd0);
      @(negedge clk);
      reset_now("rst_trap");
      step("tr_exit_fetch", O_JUNK, 1'b0, 1'b1, V_FETCH, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
